uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//  - UART receiver, the receive-side counterpart of the TX baud generator and byte transmitter.
//  - Frame format: 8N1 by default, 8E1/8O1 when parity is compiled in. Data is sent LSB first.
//  - Contains its own 16x oversampling tick generator and an input synchronizer.
//  - Delivers each received byte with a one-cycle done pulse and error flags to the host logic.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  OSR        16          oversampling ticks per bit; fixed at 16
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  baud_set   in   4  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200,
//                     5=230400, 6=460800, 7=921600; 8..15 select 9600
//  rx         in   1  serial line, asynchronous to clk, idles high
//  data_byte  out  8  last received byte; held until the next rx_done
//  rx_done    out  1  one-cycle pulse when a frame completes
//  frame_err  out  1  one-cycle pulse coincident with rx_done when the stop bit samples 0
//  rx_busy    out  1  high from start-edge detect until the frame returns to IDLE
// BEHAVIOUR
//  - Reset values: data_byte=8'h00, rx_done=0, frame_err=0, rx_busy=0, state=IDLE, counters=0.
//  - Reset mid-frame aborts the frame immediately. There is no rx_done for the aborted frame.
//  - Synchronizer: rx passes through 2 flops (rx_s). A start edge is rx_s=0 while the previous rx_s=1.
//  - Divisor: div = CLK_FREQ/(baud*16) - 1, integer truncation, 16-bit counter.
//    - 115200 gives div=26 (one tick per 27 clk). 9600 gives div=324.
//  - baud_set is latched into the divisor register only in IDLE. Changes mid-frame have no effect.
//  - Tick counter runs only when state != IDLE. It restarts from 0 on the start edge.
//  - tick_cnt (0..15) counts ticks within a bit. The bit value is the majority of rx_s at ticks 7, 8 and 9.
//  - FSM transitions:
//    - IDLE -> START on the start edge.
//    - START: if the majority value is 1 at tick 9, the start is false; return to IDLE with no outputs.
//      Otherwise go to DATA at the bit boundary (tick 15).
//    - DATA: shift 8 bits LSB first. bit_cnt counts 0..7. After bit 7 go to STOP (or PARITY).
//    - STOP: at tick 9, decide the stop bit and pulse rx_done on the next clk.
//      - Update data_byte in that same cycle.
//      - Pulse frame_err if the stop bit sampled 0.
//      - Return to IDLE immediately, without waiting out the stop bit, so the next start edge is caught.
//  - Latency: rx_done rises 1 clk after the stop-bit decision tick. That is about 9.5 bit times after the start edge.
//  - A frame_err with rx held low does not re-trigger. A new start requires rx_s to go 1 and then 0.
//  - rx_busy falls in the same cycle rx_done rises.
// CONFIGURATION
//  - Macro UART_RX_PARITY_EN:
//    - Defined:
//      - Adds input parity_odd (1 = odd parity, 0 = even parity), latched in IDLE.
//      - Adds output parity_err, reset value 0.
//      - Adds state PARITY between DATA and STOP, sampled the same way as data bits.
//      - parity_err pulses together with rx_done when ^data ^ parity_bit != parity_odd.
//    - Undefined: 8N1 only. No parity ports and no PARITY state.
// TESTING
//  1. baud_set=4, send 8'hA5 8N1 -> data_byte=8'hA5, rx_done pulses one cycle about 4104 clk after the start edge, frame_err=0.
//  2. baud_set=0, send 8'h00 then 8'hFF back-to-back (no idle gap) -> two rx_done pulses, bytes 8'h00 then 8'hFF.
//  3. baud_set=4, rx low pulse of 5 ticks (135 clk) -> false start, no rx_done, rx_busy returns to 0.
//  4. baud_set=4, send 8'h3C with the stop bit forced 0 -> rx_done and frame_err pulse together, data_byte=8'h3C.
//  5. Assert rst during bit 4 of 8'h55 -> all outputs 0 immediately; the next valid frame 8'h81 is received correctly.
//  6. With UART_RX_PARITY_EN, parity_odd=0:
//     - send 8'h07 with parity bit 1 -> parity_err=0.
//     - send 8'h07 with parity bit 0 -> parity_err pulses with rx_done.

Source files
------------

// File: rtl/uart_byte_rx.sv
`default_nettype none
//==============================================================================
// Module   : uart_byte_rx
// Purpose  : 16x-oversampled UART byte receiver with input synchronizer.
//            8N1 by default; UART_RX_PARITY_EN adds an even/odd parity bit.
// Revision : 1.0 - initial release
//==============================================================================
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int OSR      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] baud_set,
    input  logic       rx,
`ifdef UART_RX_PARITY_EN
    input  logic       parity_odd,
    output logic       parity_err,
`endif
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] c_div_9600   = 16'(CLK_FREQ / (9600   * OSR) - 1);
    localparam logic [15:0] c_div_19200  = 16'(CLK_FREQ / (19200  * OSR) - 1);
    localparam logic [15:0] c_div_38400  = 16'(CLK_FREQ / (38400  * OSR) - 1);
    localparam logic [15:0] c_div_57600  = 16'(CLK_FREQ / (57600  * OSR) - 1);
    localparam logic [15:0] c_div_115200 = 16'(CLK_FREQ / (115200 * OSR) - 1);
    localparam logic [15:0] c_div_230400 = 16'(CLK_FREQ / (230400 * OSR) - 1);
    localparam logic [15:0] c_div_460800 = 16'(CLK_FREQ / (460800 * OSR) - 1);
    localparam logic [15:0] c_div_921600 = 16'(CLK_FREQ / (921600 * OSR) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [15:0] r_div;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_samp;
    logic [7:0]  r_shift;
    logic [7:0]  r_data_byte;
    logic        r_rx_done;
    logic        r_frame_err;
    logic        r_rx_busy;
`ifdef UART_RX_PARITY_EN
    logic        r_parity_odd;
    logic        r_par_bit;
    logic        r_parity_err;
`endif

    logic [15:0] w_div;
    logic        w_start_edge;
    logic        w_tick;
    logic        w_maj;
    logic        w_mid;
    logic        w_end;

    always_comb begin
        w_div = c_div_9600;
        case (baud_set)
            4'd1:    w_div = c_div_19200;
            4'd2:    w_div = c_div_38400;
            4'd3:    w_div = c_div_57600;
            4'd4:    w_div = c_div_115200;
            4'd5:    w_div = c_div_230400;
            4'd6:    w_div = c_div_460800;
            4'd7:    w_div = c_div_921600;
            default: w_div = c_div_9600;
        endcase
    end

    assign w_start_edge = ~r_rx_s & r_rx_prev;
    assign w_tick       = (r_div_cnt == r_div);
    // Samples from ticks 7 and 8 are held; tick 9 votes with the live value.
    assign w_maj        = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);
    assign w_mid        = w_tick && (r_tick_cnt == 4'd9);
    assign w_end        = w_tick && (r_tick_cnt == 4'd15);

    // Synchronizer flops reset to the idle level so reset release is not a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_samp      <= '0;
            r_shift     <= '0;
            r_data_byte <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_odd <= 1'b0;
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_state == S_IDLE) begin
                r_div      <= w_div;
                r_div_cnt  <= '0;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                r_parity_odd <= parity_odd;
`endif
                if (w_start_edge) begin
                    r_state   <= S_START;
                    r_rx_busy <= 1'b1;
                end
            end else begin
                r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
                if (w_tick) begin
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd7) r_samp[0] <= r_rx_s;
                    if (r_tick_cnt == 4'd8) r_samp[1] <= r_rx_s;
                end

                case (r_state)
                    S_START: begin
                        if (w_mid && w_maj) begin
                            r_state   <= S_IDLE;
                            r_rx_busy <= 1'b0;
                        end else if (w_end) begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_mid) r_shift <= {w_maj, r_shift[7:1]};
                        if (w_end) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
`else
                            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (w_mid) r_par_bit <= w_maj;
                        if (w_end) r_state <= S_STOP;
                    end
`endif
                    // Leave at mid stop bit so a start edge right after it is caught.
                    S_STOP: begin
                        if (w_mid) begin
                            r_rx_done   <= 1'b1;
                            r_data_byte <= r_shift;
                            r_frame_err <= ~w_maj;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= (^r_shift) ^ r_par_bit ^ r_parity_odd;
`endif
                            r_state     <= S_IDLE;
                            r_rx_busy   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_byte = r_data_byte;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_rx_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_byte_rx
// Purpose  : Self-checking bench for uart_byte_rx (table, directed, random).
// Revision : 1.0 - initial release
//==============================================================================
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 50_000_000;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] baud_set;
    logic       rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;
    logic       parity_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
`else
    assign parity_err = 1'b0;
`endif

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .OSR(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_set  (baud_set),
        .rx        (rx),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
        .parity_err(parity_err),
`endif
        .data_byte (data_byte),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       busy;
        longint     at;
    } done_t;

    typedef struct {
        logic [3:0] baud;
        logic [7:0] data;
        logic       stop;
        int         bc;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    longint t_start = 0;
    longint busy_cyc = 0;
    int     n_long = 0;
    int     n_orphan = 0;
    logic   prev_done = 1'b0;
    done_t  q_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done)
            q_done.push_back('{data: data_byte, ferr: frame_err, perr: parity_err,
                               busy: rx_busy, at: cyc});
        if (rx_done && prev_done) n_long++;
        if ((frame_err || parity_err) && !rx_done) n_orphan++;
        if (rx_busy) busy_cyc++;
        prev_done = rx_done;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic int rate_of(input logic [3:0] s);
        case (s)
            4'd1: return 19200;
            4'd2: return 38400;
            4'd3: return 57600;
            4'd4: return 115200;
            4'd5: return 230400;
            4'd6: return 460800;
            4'd7: return 921600;
            default: return 9600;
        endcase
    endfunction

    function automatic int div_of(input logic [3:0] s);
        return CLK_FREQ / (rate_of(s) * 16) - 1;
    endfunction

    // Bit period as the receiver sees it after divisor truncation.
    function automatic int rbit(input logic [3:0] s);
        return (div_of(s) + 1) * 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit par_en,
                              input logic par, input int bc, input bit scramble,
                              input logic [3:0] keep_baud);
        rx = 1'b0;
        t_start = cyc;
        idle(bc);
        if (scramble) baud_set = 4'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bc);
        end
        if (par_en) begin
            rx = par;
            idle(bc);
        end
        if (scramble) baud_set = keep_baud;
        rx = stop;
        idle(bc);
    endtask

    task automatic expect_frame(input string name, input logic [7:0] b, input logic ferr,
                                input logic perr, output done_t d);
        int k;
        k = 0;
        while (q_done.size() == 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_seen"}, (q_done.size() != 0), 1'b1);
        if (q_done.size() != 0) begin
            d = q_done.pop_front();
            check({name, "_data"}, d.data, b);
            check({name, "_frame_err"}, d.ferr, ferr);
            check({name, "_parity_err"}, d.perr, perr);
            check({name, "_busy_low_at_done"}, d.busy, 1'b0);
        end else begin
            d = '{data: 8'h00, ferr: 1'b0, perr: 1'b0, busy: 1'b0, at: 0};
        end
    endtask

    initial begin
        vec_t       vt[6];
        logic [3:0] fs_tab[5];
        done_t      d;
        logic [7:0] v55;
        longint     lat;
        int         bc;

        vt[0] = '{4'd4, 8'hA5, 1'b1, CLK_FREQ / 115200, 8'hA5, 1'b0};
        vt[1] = '{4'd4, 8'h3C, 1'b0, rbit(4'd4),        8'h3C, 1'b1};
        vt[2] = '{4'd5, 8'h5A, 1'b1, rbit(4'd5),        8'h5A, 1'b0};
        vt[3] = '{4'd7, 8'hC3, 1'b1, rbit(4'd7),        8'hC3, 1'b0};
        vt[4] = '{4'd6, 8'hFE, 1'b0, rbit(4'd6),        8'hFE, 1'b1};
        vt[5] = '{4'd5, 8'h80, 1'b1, rbit(4'd5),        8'h80, 1'b0};
        fs_tab = '{4'd0, 4'd3, 4'd4, 4'd7, 4'd13};

        rst = 1'b0;
        rx = 1'b1;
        baud_set = 4'd4;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        idle(5);
        check("reset_data_byte", data_byte, 8'h00);
        check("reset_rx_done", rx_done, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_rx_busy", rx_busy, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        rst = 1'b1;
        idle(5);

        // False starts: a 5-tick low pulse; busy lasts about 10 ticks at every rate.
        for (int i = 0; i < 5; i++) begin
            int     dv;
            longint b0;
            dv = div_of(fs_tab[i]) + 1;
            baud_set = fs_tab[i];
            idle(4);
            b0 = busy_cyc;
            rx = 1'b0;
            idle(5 * dv);
            rx = 1'b1;
            idle(12 * dv);
            check("false_start_busy_len",
                  ((busy_cyc - b0) >= 9 * dv) && ((busy_cyc - b0) <= 11 * dv), 1'b1);
            check("false_start_busy_low", rx_busy, 1'b0);
            check("false_start_no_done", q_done.size(), 0);
        end

        for (int i = 0; i < 6; i++) begin
            baud_set = vt[i].baud;
            idle(4);
            check("table_quiet", q_done.size(), 0);
            send_frame(vt[i].data, vt[i].stop, PAR_EN, ^vt[i].data, vt[i].bc, 1'b0, vt[i].baud);
            rx = 1'b1;
            expect_frame("table", vt[i].exp_data, vt[i].exp_ferr, 1'b0, d);
            lat = d.at - t_start;
            check("table_latency", (lat >= 9 * vt[i].bc) && (lat <= 10 * vt[i].bc), 1'b1);
            idle(4);
        end

        // Back-to-back frames with no idle gap between stop and next start.
        bc = rbit(4'd4);
        baud_set = 4'd4;
        idle(4);
        send_frame(8'h00, 1'b1, PAR_EN, 1'b0, bc, 1'b0, 4'd4);
        send_frame(8'hFF, 1'b1, PAR_EN, 1'b0, bc, 1'b0, 4'd4);
        rx = 1'b1;
        expect_frame("b2b_first", 8'h00, 1'b0, 1'b0, d);
        expect_frame("b2b_second", 8'hFF, 1'b0, 1'b0, d);

        // Framing error with the line left low: no second frame may follow.
        bc = rbit(4'd6);
        baud_set = 4'd6;
        idle(4);
        send_frame(8'h96, 1'b0, PAR_EN, ^8'h96, bc, 1'b0, 4'd6);
        idle(3 * bc);
        rx = 1'b1;
        idle(2 * bc);
        expect_frame("held_low", 8'h96, 1'b1, 1'b0, d);
        check("held_low_no_retrigger", q_done.size(), 0);

        // Reset in the middle of bit 4 of 8'h55.
        bc = rbit(4'd5);
        baud_set = 4'd5;
        v55 = 8'h55;
        idle(4);
        check("data_byte_held", data_byte, 8'h96);
        rx = 1'b0;
        idle(bc);
        for (int i = 0; i < 4; i++) begin
            rx = v55[i];
            idle(bc);
        end
        rx = v55[4];
        idle(bc / 2);
        check("busy_mid_frame", rx_busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("midreset_data_byte", data_byte, 8'h00);
        check("midreset_rx_busy", rx_busy, 1'b0);
        check("midreset_rx_done", rx_done, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        rx = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(12 * bc);
        check("midreset_no_done", q_done.size(), 0);
        send_frame(8'h81, 1'b1, PAR_EN, ^8'h81, bc, 1'b0, 4'd5);
        rx = 1'b1;
        expect_frame("after_reset", 8'h81, 1'b0, 1'b0, d);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        idle(4);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, bc, 1'b0, 4'd5);
        rx = 1'b1;
        expect_frame("parity_good", 8'h07, 1'b0, 1'b0, d);
        idle(4);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, bc, 1'b0, 4'd5);
        rx = 1'b1;
        expect_frame("parity_bad", 8'h07, 1'b0, 1'b1, d);
`endif

        // Random frames; baud_set is scrambled mid-frame and must be ignored.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] s;
            logic [7:0] b;
            logic       st;
            logic       par;
            logic       po;
            logic       exp_perr;
            s  = 4'($urandom_range(5, 7));
            b  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            bc = rbit(s);
            baud_set = s;
`ifdef UART_RX_PARITY_EN
            po  = 1'($urandom);
            par = 1'($urandom);
            parity_odd = po;
`else
            po  = 1'b0;
            par = 1'b0;
`endif
            idle($urandom_range(3, bc));
            send_frame(b, st, PAR_EN, par, bc, 1'b1, s);
            rx = 1'b1;
            exp_perr = PAR_EN && (((^b) ^ par) != po);
            expect_frame("random", b, ~st, exp_perr, d);
            lat = d.at - t_start;
            check("random_latency", (lat >= 9 * bc) && (lat <= 10 * bc), 1'b1);
        end

        idle(10);
        check("done_pulse_single_cycle", n_long, 0);
        check("error_flags_only_with_done", n_orphan, 0);
        check("no_extra_done", q_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
